// File: rtl/wb_result_stage.sv
// wb_result_stage
// Registered write-back stage in front of the register file write port.
// It selects one of five result sources and aligns and extends load data
// by funct3 and address offset. When load data has not arrived yet, it
// holds the slot in WAIT_LOAD, and it counts the cycles spent waiting.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready = state is IDLE)
//   result_src         000 ALU, 001 load, 010 PC+4, 011 imm, 100 PC+imm
//   funct3, addr_lsb   load type and low address bits
//   reg_write, rd      destination write intent and index
//   alu_result, pc_plus_4, immediate, pc_plus_imm   candidate results
//   mem_rdata/rvalid   raw memory word and its valid strobe
//   flush              kill the pending or incoming instruction
//   wb_valid/we/rd/data  registered write-back slot
//   stall_cnt          saturating count of load-wait cycles
module wb_result_stage #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            result_src,
  input  logic [2:0]            funct3,
  input  logic [2:0]            addr_lsb,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [WIDTH-1:0]      pc_plus_4,
  input  logic [WIDTH-1:0]      immediate,
  input  logic [WIDTH-1:0]      pc_plus_imm,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic [WIDTH-1:0]      wb_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [2:0] SRC_ALU  = 3'b000;
  localparam logic [2:0] SRC_LOAD = 3'b001;
  localparam logic [2:0] SRC_PC4  = 3'b010;
  localparam logic [2:0] SRC_IMM  = 3'b011;
  localparam logic [2:0] SRC_AUI  = 3'b100;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  // Fields of a missed load, held while the data is outstanding.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic                  we;
    logic [2:0]            funct3;
    logic [2:0]            addr_lsb;
  } ld_req_t;

  state_t  state, state_n;
  ld_req_t lat, lat_n;
  logic                  wb_valid_n, wb_we_n, cnt_inc;
  logic [ADDR_WIDTH-1:0] wb_rd_n;
  logic [WIDTH-1:0]      wb_data_n;

  // Extract and extend a load from the raw word. On a 32-bit datapath the
  // byte offset is limited to two bits, so word selection collapses to the
  // whole word and LWU/LD reduce to a pass-through.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] d,
                                             input logic [2:0] f3,
                                             input logic [2:0] lsb);
    logic [2:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    off = (WIDTH == 64) ? lsb : {1'b0, lsb[1:0]};
    b   = 8'(d >> {off, 3'b000});
    h   = 16'(d >> {off[2:1], 4'b0000});
    w   = 32'(d >> {off[2], 5'b00000});
    case (f3)
      3'b000:  align = WIDTH'(signed'(b));
      3'b100:  align = WIDTH'(b);
      3'b001:  align = WIDTH'(signed'(h));
      3'b101:  align = WIDTH'(h);
      3'b010:  align = WIDTH'(signed'(w));
      3'b110:  align = WIDTH'(w);
      default: align = d;
    endcase
  endfunction

  assign in_ready = (state == IDLE);

  always_comb begin
    state_n    = state;
    lat_n      = lat;
    wb_valid_n = 1'b0;
    wb_we_n    = 1'b0;
    wb_rd_n    = wb_rd;
    wb_data_n  = wb_data;
    cnt_inc    = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (in_valid) begin
        if (result_src == SRC_LOAD && !mem_rvalid) begin
          // The miss cycle itself counts as the first stall cycle.
          lat_n   = '{rd: rd, we: reg_write, funct3: funct3, addr_lsb: addr_lsb};
          state_n = WAIT_LOAD;
          cnt_inc = 1'b1;
        end else begin
          wb_valid_n = 1'b1;
          wb_rd_n    = rd;
          wb_we_n    = reg_write && (rd != '0);
          case (result_src)
            SRC_ALU:  wb_data_n = alu_result;
            SRC_LOAD: wb_data_n = align(mem_rdata, funct3, addr_lsb);
            SRC_PC4:  wb_data_n = pc_plus_4;
            SRC_IMM:  wb_data_n = immediate;
            SRC_AUI:  wb_data_n = pc_plus_imm;
            default: begin
              wb_data_n = alu_result;
              wb_we_n   = 1'b0;
            end
          endcase
        end
      end
    end else begin
      if (mem_rvalid) begin
        wb_valid_n = 1'b1;
        wb_rd_n    = lat.rd;
        wb_we_n    = lat.we && (lat.rd != '0);
        wb_data_n  = align(mem_rdata, lat.funct3, lat.addr_lsb);
        state_n    = IDLE;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat       <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_n;
      lat      <= lat_n;
      wb_valid <= wb_valid_n;
      wb_we    <= wb_we_n;
      wb_rd    <= wb_rd_n;
      wb_data  <= wb_data_n;
      if (cnt_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage. A default instance (CNT_WIDTH=16) and
// a narrow-counter instance (CNT_WIDTH=4) share all inputs; the narrow one
// shows counter saturation.
module tb_wb_result_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ready4;
  logic [2:0]  result_src, funct3, addr_lsb;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] alu_result, pc_plus_4, immediate, pc_plus_imm, mem_rdata;
  logic        mem_rvalid, flush;
  logic        wb_valid, wb_we, wb_valid4, wb_we4;
  logic [4:0]  wb_rd, wb_rd4;
  logic [31:0] wb_data, wb_data4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result_src(result_src), .funct3(funct3), .addr_lsb(addr_lsb),
    .reg_write(reg_write), .rd(rd), .alu_result(alu_result),
    .pc_plus_4(pc_plus_4), .immediate(immediate), .pc_plus_imm(pc_plus_imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_cnt(stall_cnt)
  );

  wb_result_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .result_src(result_src), .funct3(funct3), .addr_lsb(addr_lsb),
    .reg_write(reg_write), .rd(rd), .alu_result(alu_result),
    .pc_plus_4(pc_plus_4), .immediate(immediate), .pc_plus_imm(pc_plus_imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
    .wb_valid(wb_valid4), .wb_we(wb_we4), .wb_rd(wb_rd4), .wb_data(wb_data4),
    .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic we,
                      input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(v));
    chk({tag, ".we"},    64'(wb_we),    64'(we));
    chk({tag, ".rd"},    64'(wb_rd),    64'(r));
    chk({tag, ".data"},  64'(wb_data),  64'(d));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; result_src = 3'b000; funct3 = 3'b000;
    addr_lsb = 3'b000; reg_write = 1'b0; rd = 5'd0; alu_result = '0;
    pc_plus_4 = '0; immediate = '0; pc_plus_imm = '0; mem_rdata = '0;
    mem_rvalid = 1'b0; flush = 1'b0;
    #3;
    slot("reset", 1'b0, 1'b0, 5'd0, 32'h0);
    chk("reset.stall", 64'(stall_cnt), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    // ALU op, then back-to-back loads with hits
    in_valid = 1'b1; result_src = 3'b000; alu_result = 32'h0000_1234;
    rd = 5'd5; reg_write = 1'b1;
    tick(); slot("alu", 1'b1, 1'b1, 5'd5, 32'h0000_1234);
    result_src = 3'b001; mem_rdata = 32'h80FF_7F01; mem_rvalid = 1'b1;
    funct3 = 3'b000; addr_lsb = 3'd3; rd = 5'd6;
    tick(); slot("lb", 1'b1, 1'b1, 5'd6, 32'hFFFF_FF80);
    funct3 = 3'b100; addr_lsb = 3'd2;
    tick(); slot("lbu", 1'b1, 1'b1, 5'd6, 32'h0000_00FF);
    funct3 = 3'b001; addr_lsb = 3'd2;
    tick(); slot("lh", 1'b1, 1'b1, 5'd6, 32'hFFFF_80FF);
    funct3 = 3'b101; addr_lsb = 3'd0;
    tick(); slot("lhu", 1'b1, 1'b1, 5'd6, 32'h0000_7F01);

    // rd=0 suppresses write; illegal source writes ALU data without we
    result_src = 3'b010; pc_plus_4 = 32'h0000_0104; rd = 5'd0; mem_rvalid = 1'b0;
    tick(); slot("pc4_rd0", 1'b1, 1'b0, 5'd0, 32'h0000_0104);
    result_src = 3'b100; pc_plus_imm = 32'h0000_2040; rd = 5'd8;
    tick(); slot("auipc", 1'b1, 1'b1, 5'd8, 32'h0000_2040);
    result_src = 3'b101; alu_result = 32'h0000_AAAA; rd = 5'd7;
    tick(); slot("illegal", 1'b1, 1'b0, 5'd7, 32'h0000_AAAA);
    in_valid = 1'b0;
    tick(); slot("idle_hold", 1'b0, 1'b0, 5'd7, 32'h0000_AAAA);

    // Load miss: rvalid low in accept cycle and two wait cycles
    in_valid = 1'b1; result_src = 3'b001; funct3 = 3'b010; addr_lsb = 3'd0;
    rd = 5'd9; reg_write = 1'b1; mem_rvalid = 1'b0;
    tick();
    chk("miss.valid0", 64'(wb_valid), 64'd0);
    chk("miss.ready0", 64'(in_ready), 64'd0);
    chk("miss.cnt1", 64'(stall_cnt), 64'd1);
    in_valid = 1'b0; funct3 = 3'b000; addr_lsb = 3'd3; rd = 5'd1;
    tick();
    chk("miss.ready1", 64'(in_ready), 64'd0);
    tick();
    chk("miss.ready2", 64'(in_ready), 64'd0);
    chk("miss.cnt3", 64'(stall_cnt), 64'd3);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); slot("miss.wb", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    chk("miss.cnt_final", 64'(stall_cnt), 64'd3);
    chk("miss.ready_back", 64'(in_ready), 64'd1);
    // rvalid in IDLE with no load is ignored
    tick(); slot("stray_rvalid", 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF);

    // Flush in WAIT_LOAD together with rvalid
    mem_rvalid = 1'b0; in_valid = 1'b1; rd = 5'd10; funct3 = 3'b010;
    tick();
    chk("flw.ready0", 64'(in_ready), 64'd0);
    in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    chk("flw.valid", 64'(wb_valid), 64'd0);
    chk("flw.we", 64'(wb_we), 64'd0);
    chk("flw.ready", 64'(in_ready), 64'd1);
    chk("flw.cnt", 64'(stall_cnt), 64'd4);
    flush = 1'b0;
    tick(); slot("flw.after", 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF);

    // Flush of an incoming ALU op
    mem_rvalid = 1'b0; in_valid = 1'b1; flush = 1'b1; result_src = 3'b000;
    alu_result = 32'h0000_0BAD; rd = 5'd11;
    tick(); slot("fl_in", 1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF);
    flush = 1'b0; in_valid = 1'b0;

    // Reset asserted mid-WAIT_LOAD
    in_valid = 1'b1; result_src = 3'b001; rd = 5'd12;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rstw.cnt", 64'(stall_cnt), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    slot("rstw", 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rstw.cnt0", 64'(stall_cnt), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
    @(negedge clk); rst_n = 1'b1;
    tick(); slot("rstw.after", 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rstw.ready", 64'(in_ready), 64'd1);

    // 20 stall cycles: 16-bit counter reads 20, 4-bit counter saturates
    mem_rvalid = 1'b0; in_valid = 1'b1; result_src = 3'b001; rd = 5'd13;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("sat.cnt16", 64'(stall_cnt), 64'd20);
    chk("sat.cnt4", 64'(stall_cnt4), 64'd15);
    tick();
    chk("sat.cnt4_hold", 64'(stall_cnt4), 64'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat.ready", 64'(in_ready4), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Registered, parametrised write-back stage that replaces the combinational result select in front of the register file. It selects among five result sources and aligns and extends load data by funct3 and address offset. It also holds the write-back slot while a load waits on late cache data, and counts those stall cycles. It sits between the memory stage and the register file write port.

## Interface
Parameters:
- WIDTH, 32: datapath width; legal values are 32 or 64.
- ADDR_WIDTH, 5: register index width.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is presented this cycle.
- in_ready  out  1  the stage can accept an instruction.
- result_src  in  3  source select: 000 ALU, 001 load, 010 PC+4, 011 immediate, 100 PC+imm (AUIPC). Codes 101–111 are illegal.
- funct3  in  3  load type; only meaningful when result_src=001.
- addr_lsb  in  3  low bits of the load address; bit 2 is used only when WIDTH=64.
- reg_write  in  1  the instruction writes rd.
- rd  in  ADDR_WIDTH  destination register.
- alu_result, pc_plus_4, immediate, pc_plus_imm  in  WIDTH  candidate results.
- mem_rdata  in  WIDTH  raw, unaligned memory/cache data word.
- mem_rvalid  in  1  mem_rdata is valid this cycle.
- flush  in  1  kill the pending or incoming instruction.
- wb_valid  out  1  write-back slot is valid this cycle.
- wb_we  out  1  register-file write enable.
- wb_rd  out  ADDR_WIDTH  register-file write address.
- wb_data  out  WIDTH  register-file write data.
- stall_cnt  out  CNT_WIDTH  saturating count of load-wait cycles.

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. Reset enters IDLE.
- in_ready = (state==IDLE). It is combinational.
- IDLE, in_valid, no flush, non-load source:
  - Register wb_data from the selected source.
  - wb_rd = rd.
  - wb_we = reg_write && rd!=0.
  - wb_valid = 1.
- IDLE, in_valid, load, mem_rvalid=1: same as above, using the aligned load data.
- IDLE, in_valid, load, mem_rvalid=0:
  - Latch rd, reg_write, funct3 and addr_lsb.
  - Move to WAIT_LOAD.
  - wb_valid = 0.
- WAIT_LOAD:
  - Each cycle without mem_rvalid increments stall_cnt; it saturates at all-ones.
  - On mem_rvalid, register the aligned data using the latched fields, set wb_valid=1, and return to IDLE.
- Load alignment:
  - LB (000): sign-extend the byte selected by addr_lsb.
  - LBU (100): zero-extend the byte selected by addr_lsb.
  - LH (001): sign-extend the halfword selected by addr_lsb[2:1].
  - LHU (101): zero-extend the halfword selected by addr_lsb[2:1].
  - LW (010): sign-extend the selected word; this is the full word when WIDTH=32.
  - LWU (110): zero-extend the selected word. WIDTH=64 only.
  - LD (011): the full word. WIDTH=64 only.
  - Any other funct3 passes mem_rdata through unchanged.
  - Misalignment is not checked here; low address bits beyond the access size are ignored.
- Illegal result_src codes write ALU data with wb_we forced to 0.
- flush has priority over everything:
  - The next-cycle wb_valid and wb_we are 0.
  - WAIT_LOAD is abandoned and the state returns to IDLE.
  - A mem_rvalid arriving in the same cycle is discarded.
- When wb_valid=0, wb_we=0. wb_data and wb_rd hold their last values.
- Asynchronous reset mid-load drops the load. No write is issued.

## Timing
- Reset values:
  - wb_valid = 0
  - wb_we = 0
  - wb_rd = 0
  - wb_data = 0
  - stall_cnt = 0
  - state = IDLE
  - in_ready = 1 once rst_n is deasserted.
- Latency is one cycle. An instruction accepted at edge N, with data available, shows on wb_* after edge N, valid for exactly one cycle.
- A load miss accepted at N, with mem_rvalid first high in cycle N+k (k≥1), gives:
  - wb_valid high for the one cycle after edge N+k.
  - stall_cnt increased by k.
- Back-to-back accepts in IDLE give one wb_valid per cycle, with no bubbles.
- in_valid while in_ready=0 is ignored. Upstream must hold the instruction.
- mem_rvalid in IDLE without a load is ignored.
- stall_cnt never wraps.

## Test plan
- Reset then ALU op: alu_result=0x0000_1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x0000_1234.
- LB with a hit: mem_rdata=0x80FF_7F01, addr_lsb=3 → wb_data=0xFFFF_FF80. LBU with addr_lsb=2 → wb_data=0x0000_00FF. LH with addr_lsb=2 → wb_data=0xFFFF_80FF.
- Load miss: mem_rvalid low for 3 cycles, then high with 0xDEAD_BEEF, LW → in_ready=0 for 3 cycles, wb_data=0xDEAD_BEEF once, stall_cnt=3.
- rd=0 with reg_write=1, PC+4 source → wb_valid=1, wb_we=0.
- Flush while in WAIT_LOAD, in the same cycle as mem_rvalid → no wb_valid; the next cycle in_ready=1.
- Reset asserted mid-WAIT_LOAD → all outputs reset immediately; no write-back after release. With CNT_WIDTH=4, 20 stall cycles → stall_cnt=15.
